register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file.sv | 153 +++++++++++++++
 tb/tb_register_file.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// Multi-ported register file with a per-register pending (reservation)
// scoreboard. Two combinational read ports with write-through bypass, one
// synchronous write port, and a reserve/flush interface for tracking
// registers whose producer has not yet written back.
//
// Optional hard-wired zero register: when zero_reg is set, register 0 reads
// as zero, never becomes pending, and silently drops writes.

module register_file #(
  parameter int unsigned bits     = 4,
  parameter int unsigned count    = 8,
  parameter bit          zero_reg = 1'b0,
  localparam int unsigned A       = $clog2(count)
) (
  input  logic            clk,
  input  logic            rst,

  // Write port
  input  logic            wenable,
  input  logic [A-1:0]    waddr,
  input  logic [bits-1:0] wdata,

  // Read ports
  input  logic [A-1:0]    raddr1,
  input  logic [A-1:0]    raddr2,
  output logic [bits-1:0] rdata1,
  output logic [bits-1:0] rdata2,

  // Reservation scoreboard
  input  logic            reserve,
  input  logic [A-1:0]    reserve_addr,
  input  logic            flush,
  output logic            busy1,
  output logic            busy2,
  output logic            busy_any
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [bits-1:0]  regs_q [count];
  logic [bits-1:0]  regs_d [count];
  logic [count-1:0] pending_q;
  logic [count-1:0] pending_d;

  // One-hot selects for the register being written / reserved this cycle.
  logic [count-1:0] wr_sel;
  logic [count-1:0] rsv_sel;

  // Qualified strobes: a hard-wired zero register swallows writes and
  // reservations aimed at address 0.
  logic wr_ok;
  logic rsv_ok;

  // Qualify the write and reserve strobes against the zero register.
  always_comb begin
    wr_ok  = wenable && !(zero_reg && (waddr == '0));
    rsv_ok = reserve && !(zero_reg && (reserve_addr == '0));
  end

  // Decode write and reserve addresses to one-hot register selects.
  always_comb begin
    wr_sel  = '0;
    rsv_sel = '0;
    if (wr_ok) begin
      wr_sel[waddr] = 1'b1;
    end
    if (rsv_ok) begin
      rsv_sel[reserve_addr] = 1'b1;
    end
  end

  // Next-state data: only the selected register loads the write data.
  always_comb begin
    for (int i = 0; i < count; i++) begin
      regs_d[i] = wr_sel[i] ? wdata : regs_q[i];
    end
  end

  // Next-state pending: a write retires the reservation, a reservation in the
  // same cycle re-arms it (a newer producer owns the register), and flush
  // overrides everything.
  always_comb begin
    pending_d = '0;
    if (!flush) begin
      pending_d = rsv_sel | (pending_q & ~wr_sel);
    end
  end

  // Storage and scoreboard registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < count; i++) begin
        regs_q[i] <= '0;
      end
      pending_q <= '0;
    end else begin
      for (int i = 0; i < count; i++) begin
        regs_q[i] <= regs_d[i];
      end
      pending_q <= pending_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  // Address-0 hits on a hard-wired zero register.
  logic rd1_zero;
  logic rd2_zero;
  // Write-through bypass hits. wr_ok already excludes the zero register, so
  // a dropped write to address 0 never bypasses.
  logic rd1_byp;
  logic rd2_byp;

  // Classify each read address.
  always_comb begin
    rd1_zero = zero_reg && (raddr1 == '0);
    rd2_zero = zero_reg && (raddr2 == '0);
    rd1_byp  = wr_ok && (waddr == raddr1);
    rd2_byp  = wr_ok && (waddr == raddr2);
  end

  // Read port 1 data: reset forces zero, then zero register, then bypass.
  always_comb begin
    rdata1 = '0;
    if (!rst && !rd1_zero) begin
      rdata1 = rd1_byp ? wdata : regs_q[raddr1];
    end
  end

  // Read port 2 data, same priority as port 1.
  always_comb begin
    rdata2 = '0;
    if (!rst && !rd2_zero) begin
      rdata2 = rd2_byp ? wdata : regs_q[raddr2];
    end
  end

  // Busy flags reflect registered pending state only; an in-flight write
  // does not clear busy until the edge that retires it.
  always_comb begin
    busy1    = 1'b0;
    busy2    = 1'b0;
    busy_any = 1'b0;
    if (!rst) begin
      busy1    = !rd1_zero && pending_q[raddr1];
      busy2    = !rd2_zero && pending_q[raddr2];
      busy_any = |pending_q;
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: expectations are queued on a scoreboard
// as each step is driven and popped when the outputs are sampled.

module tb_register_file;

  localparam int unsigned Bits  = 4;
  localparam int unsigned Count = 8;
  localparam int unsigned A     = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            wenable;
  logic [A-1:0]    waddr;
  logic [Bits-1:0] wdata;
  logic [A-1:0]    raddr1;
  logic [A-1:0]    raddr2;
  logic            reserve;
  logic [A-1:0]    reserve_addr;
  logic            flush;

  logic [Bits-1:0] rdata1, rdata2, z_rdata1, z_rdata2;
  logic            busy1, busy2, busy_any, z_busy1, z_busy2, z_busy_any;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } sb_t;

  sb_t sb_q[$];

  register_file #(.bits(Bits), .count(Count), .zero_reg(1'b0)) dut (
    .clk(clk), .rst(rst), .wenable(wenable), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .reserve(reserve), .reserve_addr(reserve_addr), .flush(flush),
    .busy1(busy1), .busy2(busy2), .busy_any(busy_any)
  );

  register_file #(.bits(Bits), .count(Count), .zero_reg(1'b1)) dut_z (
    .clk(clk), .rst(rst), .wenable(wenable), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(z_rdata1), .rdata2(z_rdata2),
    .reserve(reserve), .reserve_addr(reserve_addr), .flush(flush),
    .busy1(z_busy1), .busy2(z_busy2), .busy_any(z_busy_any)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [63:0] v);
    sb_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input logic [63:0] obs);
    sb_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %0h required an entry", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  // Advance past the next rising edge, landing clear of it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wenable = 1'b0;
    reserve = 1'b0;
    flush   = 1'b0;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "bench timed out");
  end

  initial begin
    // Reset with no clock edge yet: write, reserve and bypass all suppressed.
    rst = 1'b1; wenable = 1'b1; waddr = 3'd3; wdata = 4'b1111;
    raddr1 = 3'd3; raddr2 = 3'd3; reserve = 1'b1; reserve_addr = 3'd3; flush = 1'b0;
    push("rst_rdata1", 64'h0); push("rst_rdata2", 64'h0); push("rst_busy_any", 64'h0);
    #2;
    pop_check(64'(rdata1)); pop_check(64'(rdata2)); pop_check(64'(busy_any));
    tick();  // edge while held in reset
    rst = 1'b0;
    idle_inputs();
    push("post_rst_rdata1", 64'h0); push("post_rst_busy1", 64'h0);
    #2;
    pop_check(64'(rdata1)); pop_check(64'(busy1));

    // Write r3 and r5, read both back; disabled write leaves them alone.
    wenable = 1'b1; waddr = 3'd3; wdata = 4'b1010;
    tick();
    waddr = 3'd5; wdata = 4'b0101;
    tick();
    wenable = 1'b0; waddr = 3'd3; wdata = 4'b1111; raddr1 = 3'd3; raddr2 = 3'd5;
    push("wr_r3", 64'hA); push("wr_r5", 64'h5);
    #2;
    pop_check(64'(rdata1)); pop_check(64'(rdata2));
    tick();
    push("nowr_r3", 64'hA); push("nowr_r5", 64'h5);
    #2;
    pop_check(64'(rdata1)); pop_check(64'(rdata2));

    // Bypass before the edge, then stored value after it.
    wenable = 1'b1; waddr = 3'd2; wdata = 4'b1100; raddr1 = 3'd2; raddr2 = 3'd5;
    push("bypass_rdata1", 64'hC); push("bypass_other_port", 64'h5);
    #2;
    pop_check(64'(rdata1)); pop_check(64'(rdata2));
    tick();
    wenable = 1'b0; wdata = 4'b0000; raddr2 = 3'd2;
    push("stored_r2_port1", 64'hC); push("stored_r2_port2", 64'hC);
    #2;
    pop_check(64'(rdata1)); pop_check(64'(rdata2));

    // Reserve r4, then retire it with a write; busy holds until the edge.
    reserve = 1'b1; reserve_addr = 3'd4;
    tick();
    reserve = 1'b0; raddr1 = 3'd4;
    push("rsv_busy1", 64'h1); push("rsv_busy_any", 64'h1);
    #2;
    pop_check(64'(busy1)); pop_check(64'(busy_any));
    wenable = 1'b1; waddr = 3'd4; wdata = 4'b0011;
    push("busy_no_bypass", 64'h1);
    #2;
    pop_check(64'(busy1));
    tick();
    wenable = 1'b0;
    push("retire_busy1", 64'h0); push("retire_busy_any", 64'h0); push("retire_data", 64'h3);
    #2;
    pop_check(64'(busy1)); pop_check(64'(busy_any)); pop_check(64'(rdata1));

    // Reserve and write the same register together: reservation wins.
    reserve = 1'b1; reserve_addr = 3'd4; wenable = 1'b1; waddr = 3'd4; wdata = 4'b0110;
    tick();
    idle_inputs();
    push("rsv_wins_busy1", 64'h1); push("rsv_wins_data", 64'h6);
    #2;
    pop_check(64'(busy1)); pop_check(64'(rdata1));

    // Flush clears every reservation and beats a same-cycle reserve.
    reserve = 1'b1; reserve_addr = 3'd1;
    tick();
    reserve_addr = 3'd6;
    tick();
    reserve_addr = 3'd2; flush = 1'b1;
    tick();
    idle_inputs();
    raddr1 = 3'd2; raddr2 = 3'd6;
    push("flush_busy1", 64'h0); push("flush_busy2", 64'h0);
    push("flush_busy_any", 64'h0); push("flush_keeps_data", 64'hC);
    #2;
    pop_check(64'(busy1)); pop_check(64'(busy2));
    pop_check(64'(busy_any)); pop_check(64'(rdata1));

    // Zero register: write and reserve of r0 ignored, no bypass on r0.
    wenable = 1'b1; waddr = 3'd0; wdata = 4'b1111; reserve = 1'b1; reserve_addr = 3'd0;
    raddr1 = 3'd0; raddr2 = 3'd3;
    push("z_no_bypass", 64'h0); push("nz_bypass_r0", 64'hF);
    #2;
    pop_check(64'(z_rdata1)); pop_check(64'(rdata1));
    tick();
    idle_inputs();
    push("z_rdata1", 64'h0); push("z_busy1", 64'h0); push("z_busy_any", 64'h0);
    push("z_r3_normal", 64'hA); push("nz_r0_written", 64'hF); push("nz_r0_busy", 64'h1);
    #2;
    pop_check(64'(z_rdata1)); pop_check(64'(z_busy1)); pop_check(64'(z_busy_any));
    pop_check(64'(z_rdata2)); pop_check(64'(rdata1)); pop_check(64'(busy1));

    // Both ports on the same address.
    raddr1 = 3'd5; raddr2 = 3'd5;
    push("same_addr_p1", 64'h5); push("same_addr_p2", 64'h5);
    #2;
    pop_check(64'(rdata1)); pop_check(64'(rdata2));

    // Mid-operation reset: r7 written and reserved, then cleared asynchronously.
    wenable = 1'b1; waddr = 3'd7; wdata = 4'b1001; reserve = 1'b1; reserve_addr = 3'd7;
    tick();
    idle_inputs();
    raddr1 = 3'd7; raddr2 = 3'd7;
    push("r7_data", 64'h9); push("r7_busy", 64'h1);
    #2;
    pop_check(64'(rdata1)); pop_check(64'(busy1));
    rst = 1'b1;
    wenable = 1'b1; waddr = 3'd7; wdata = 4'b0101;
    push("midrst_rdata1", 64'h0); push("midrst_rdata2", 64'h0);
    push("midrst_busy1", 64'h0); push("midrst_busy_any", 64'h0);
    #1;
    pop_check(64'(rdata1)); pop_check(64'(rdata2));
    pop_check(64'(busy1)); pop_check(64'(busy_any));
    tick();
    rst = 1'b0;
    idle_inputs();
    raddr1 = 3'd3;
    push("after_rst_r7", 64'h0); push("after_rst_r3", 64'h0); push("after_rst_busy_any", 64'h0);
    #2;
    pop_check(64'(rdata2)); pop_check(64'(rdata1)); pop_check(64'(busy_any));

    // Normal operation resumes on the next edge.
    wenable = 1'b1; waddr = 3'd7; wdata = 4'b0101;
    tick();
    idle_inputs();
    push("resume_r7", 64'h5);
    #2;
    pop_check(64'(rdata2));

    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover: observed %0d entries required 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
